// File: rtl/step_profile_pkg.sv
// step_profile_pkg: FSM states and default timing shared with stepper_motor_driver
package step_profile_pkg;
    typedef enum logic [2:0] {IDLE, DIR_SETUP, ACCEL, CRUISE, DECEL} state_t;
    localparam int DEF_DEBOUNCE_CYCLES  = 500_000;
    localparam int DEF_PERIOD_W         = 20;
    localparam int DEF_MAX_PERIOD       = 250_000;
    localparam int DEF_MIN_PERIOD       = 25_000;
    localparam int DEF_ACCEL_STEP       = 2_500;
    localparam int DEF_STEP_HIGH_CYCLES = 100;
    localparam int DEF_DIR_SETUP_CYCLES = 50;
endpackage

// File: rtl/step_profile_generator_switch_debouncer.sv
// switch_debouncer: 2-FF synchronizer followed by a stability counter
import step_profile_pkg::*;

module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic db_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            db_out <= 1'b0;
        end else begin
            sync <= {sync[0], raw_in};
            if (sync[1] == db_out)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                db_out <= sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/step_profile_generator.sv
// step_profile_generator: debounced enable/dir to a ramped step/dir pulse train;
// every reversal decelerates to a stop and re-runs the dir setup time.
import step_profile_pkg::*;

module step_profile_generator #(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int PERIOD_W         = DEF_PERIOD_W,
    parameter int MAX_PERIOD       = DEF_MAX_PERIOD,
    parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
    parameter int ACCEL_STEP       = DEF_ACCEL_STEP,
    parameter int STEP_HIGH_CYCLES = DEF_STEP_HIGH_CYCLES,
    parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dir_switch_in,
    input  logic                enable_switch_in,
    output logic                step_out,
    output logic                dir_out,
    output logic                busy,
    output logic                at_speed,
    output logic [PERIOD_W-1:0] cur_period
);
    localparam int SW = $clog2(DIR_SETUP_CYCLES + 1);
    localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    if (!(STEP_HIGH_CYCLES < MIN_PERIOD && MIN_PERIOD <= MAX_PERIOD &&
          MAX_PERIOD < 2**PERIOD_W && ACCEL_STEP >= 1 &&
          DIR_SETUP_CYCLES >= 1 && DEBOUNCE_CYCLES >= 1)) begin : g_bad_params
        $error("step_profile_generator: illegal parameters");
    end

    logic en_db, dir_db;
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_db (
        .clk(clk), .reset(reset), .raw_in(enable_switch_in), .db_out(en_db));
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
        .clk(clk), .reset(reset), .raw_in(dir_switch_in), .db_out(dir_db));

    state_t              state, state_n;
    logic [PERIOD_W-1:0] pc, pc_n, per_n, dec;
    logic [PERIOD_W:0]   sum;
    logic [SW-1:0]       sc, sc_n;
    logic                dir_n, step_n, bnd, stop, inc_top;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            sc         <= '0;
            cur_period <= MAX_P;
            dir_out    <= 1'b0;
            step_out   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            sc         <= sc_n;
            cur_period <= per_n;
            dir_out    <= dir_n;
            step_out   <= step_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        per_n   = cur_period;
        dir_n   = dir_out;
        sc_n    = sc;
        bnd     = pc == cur_period - 1'b1;
        stop    = !en_db || (dir_db != dir_out);
        sum     = {1'b0, cur_period} + (PERIOD_W+1)'(ACCEL_STEP);
        inc_top = sum >= (PERIOD_W+1)'(MAX_PERIOD);
        dec     = ({1'b0, cur_period} > (PERIOD_W+1)'(MIN_PERIOD + ACCEL_STEP)) ?
                  cur_period - PERIOD_W'(ACCEL_STEP) : MIN_P;
        case (state)
            IDLE: begin
                per_n = MAX_P;
                pc_n  = '0;
                if (en_db) begin
                    dir_n   = dir_db;
                    sc_n    = SW'(DIR_SETUP_CYCLES - 1);
                    state_n = DIR_SETUP;
                end
            end
            DIR_SETUP: begin
                sc_n    = (sc == '0) ? sc : sc - 1'b1;
                state_n = (sc == '0) ? ACCEL : DIR_SETUP;
            end
            default: begin
                pc_n = bnd ? '0 : pc + 1'b1;
                // Stop requests are taken only at a boundary so a pulse is never cut short
                if (bnd && (state == DECEL || stop)) begin
                    per_n   = inc_top ? MAX_P : sum[PERIOD_W-1:0];
                    state_n = inc_top ? IDLE : (stop ? DECEL : ACCEL);
                end else if (bnd) begin
                    per_n   = dec;
                    state_n = (dec == MIN_P) ? CRUISE : ACCEL;
                end
            end
        endcase
        step_n = (state_n inside {ACCEL, CRUISE, DECEL}) && pc_n < PERIOD_W'(STEP_HIGH_CYCLES);
    end

    assign busy     = state != IDLE;
    assign at_speed = state == CRUISE;
endmodule

// File: tb/tb_step_profile_generator.sv
// tb_step_profile_generator: directed checks of ramp timing, debounce, stop, reversal and reset
module tb_step_profile_generator;
    logic       clk = 0, reset = 1, dir_sw = 0, en_sw = 0;
    logic       step_out, dir_out, busy, at_speed;
    logic [7:0] cur_period;
    int errors = 0, checks = 0, cyc = 0, nr = 0, nw = 0, hi = 0;
    int busy_fall = -1, dir_chg = -1, dir_viol = 0, t0, e;
    int rise_t[64], rise_dir[64], rise_as[64], rise_per[64], widths[64];
    int exp_p[6] = '{40, 35, 30, 25, 20, 20};
    int exp_d[3] = '{20, 45, 75};
    logic p_step = 0, p_busy = 0, p_dir = 0, busy_seen = 0;

    always #5 clk = ~clk;

    step_profile_generator #(
        .DEBOUNCE_CYCLES(8), .PERIOD_W(8), .MAX_PERIOD(40), .MIN_PERIOD(20),
        .ACCEL_STEP(5), .STEP_HIGH_CYCLES(4), .DIR_SETUP_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .dir_switch_in(dir_sw), .enable_switch_in(en_sw),
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .at_speed(at_speed),
        .cur_period(cur_period)
    );

    // Post-edge monitor: cyc counts rising edges seen so far
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (step_out && !p_step && nr < 64) begin
            rise_t[nr] = cyc;
            rise_dir[nr] = int'(dir_out);
            rise_as[nr] = int'(at_speed);
            rise_per[nr] = int'(cur_period);
            nr++;
            hi = 0;
        end
        if (step_out) hi++;
        if (!step_out && p_step && nw < 64) begin
            widths[nw] = hi;
            nw++;
        end
        if (busy) busy_seen = 1;
        if (!busy && p_busy) busy_fall = cyc;
        if (dir_out != p_dir) begin
            dir_chg = cyc;
            if (p_busy) dir_viol++;
        end
        p_step = step_out;
        p_busy = busy;
        p_dir = dir_out;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (nr < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (nr < n) check("rise_timeout", nr, n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        dir_sw = 1;
        en_sw = 1;
        reset = 1;
        repeat (5) @(negedge clk);
        check("rst_step", int'(step_out), 0);
        check("rst_dir", int'(dir_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_at_speed", int'(at_speed), 0);
        check("rst_period", int'(cur_period), 40);
        reset = 0;
        t0 = cyc;
        nr = 0;
        nw = 0;
        wait_rises(7, 300);
        check("first_rise_latency", rise_t[0] - t0, 14);
        check("ramp_dir", rise_dir[0], 1);
        for (int i = 0; i < 6; i++) check($sformatf("ramp_period%0d", i), rise_t[i+1] - rise_t[i], exp_p[i]);
        check("at_speed_p25", rise_as[3], 0);
        check("at_speed_p20", rise_as[4], 1);
        check("width_first", widths[0], 4);
        check("width_cruise", widths[5], 4);

        nr = 0;
        wait_rises(1, 40);
        e = rise_t[0];
        en_sw = 0;
        nr = 0;
        busy_fall = -1;
        wait_idle(200);
        repeat (60) @(negedge clk);
        check("stop_rises", nr, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stop_rise%0d", i), rise_t[i] - e, exp_d[i]);
            check($sformatf("stop_period%0d", i), rise_per[i], 25 + 5 * i);
        end
        check("stop_idle_time", busy_fall - e, 110);
        check("stop_busy", int'(busy), 0);
        check("stop_period_reload", int'(cur_period), 40);

        nr = 0;
        busy_seen = 0;
        en_sw = 1;
        repeat (5) @(negedge clk);
        en_sw = 0;
        repeat (30) @(negedge clk);
        check("glitch_busy", int'(busy_seen), 0);
        check("glitch_rises", nr, 0);

        nr = 0;
        en_sw = 1;
        wait_rises(6, 400);
        check("cruise_at_speed", int'(at_speed), 1);
        e = rise_t[5];
        dir_sw = 0;
        nr = 0;
        busy_fall = -1;
        dir_chg = -1;
        dir_viol = 0;
        wait_rises(5, 300);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rev_rise%0d", i), rise_t[i] - e, exp_d[i]);
            check($sformatf("rev_dir%0d", i), rise_dir[i], 1);
        end
        check("rev_idle_time", busy_fall - e, 110);
        check("rev_dir_change", dir_chg - e, 111);
        check("rev_new_rise", rise_t[3] - e, 114);
        check("rev_new_dir", rise_dir[3], 0);
        check("rev_new_period", rise_per[3], 40);
        check("rev_second_period", rise_t[4] - rise_t[3], 40);
        check("dir_while_busy", dir_viol, 0);

        check("pre_reset_step", int'(step_out), 1);
        reset = 1;
        @(negedge clk);
        check("midrst_step", int'(step_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_at_speed", int'(at_speed), 0);
        check("midrst_period", int'(cur_period), 40);
        reset = 0;
        en_sw = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
